// File: rtl/text_pixel_gen.sv
// text_pixel_gen
//   Text-mode pixel renderer. It maps each pixel coordinate to a character
//   cell and issues the text-RAM read address. The returned character code
//   becomes the font-memory glyph address. One bit of the returned 8x16 glyph
//   bitmap is then selected, optionally inverted, and blanked.
//   Pixel, rgb, active, hsync and vsync all leave exactly 4 clocks after the
//   coordinate is presented.
//
// Ports
//   clk, rstn            pixel clock, asynchronous active-low reset
//   hpos, vpos           current pixel coordinate
//   active_in            visible-area flag
//   hsync_in, vsync_in   syncs from the timing generator
//   char_addr            registered text-RAM read address
//   char_data            text-RAM read data (1 clock after char_addr)
//   font_addr            glyph index = char_data[6:0], combinational
//   font_data            glyph bitmap (1 clock after font_addr);
//                        bit row*8+col, where bit 0 is the top-left pixel
//   pixel, rgb           rendered pixel and its colour
//   active_out, hsync_out, vsync_out   sidebands delayed 4 clocks
//
// Optional build macro TEXT_CURSOR_EN
//   Adds the cursor_col and cursor_row inputs and a vsync frame counter.
//   The cursor draws an underline on scanlines 14-15 of the cursor cell.
//   It blinks 16 frames on and 16 frames off.
module text_pixel_gen #(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned POS_W       = 10,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned FONT_ADDR_W = 7,
  parameter int unsigned COLOR_W     = 3,
  parameter logic [COLOR_W-1:0] FG_COLOR = 3'b111,
  parameter logic [COLOR_W-1:0] BG_COLOR = 3'b000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [POS_W-1:0]       hpos,
  input  logic [POS_W-1:0]       vpos,
  input  logic                   active_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]             cursor_col,
  input  logic [4:0]             cursor_row,
`endif
  output logic [ADDR_W-1:0]      char_addr,
  input  logic [7:0]             char_data,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [127:0]           font_data,
  output logic                   pixel,
  output logic [COLOR_W-1:0]     rgb,
  output logic                   active_out,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  if (COLS * ROWS > 2 ** ADDR_W) begin : g_param_check
    $error("text_pixel_gen: COLS*ROWS does not fit in ADDR_W bits");
  end

  localparam int unsigned CX_W = POS_W - 3;
  localparam int unsigned CY_W = POS_W - 4;

  // Sideband that travels alongside the memory reads.
  // vis is active_in masked by the on-screen check. act is the raw active_in,
  // which is forwarded to active_out.
  typedef struct packed {
    logic       cur;
    logic       vis;
    logic       act;
    logic       hs;
    logic       vs;
    logic [3:0] vsub;
    logic [2:0] hsub;
  } side_t;

  logic [CX_W-1:0]    cell_x;
  logic [CY_W-1:0]    cell_y;
  logic               in_range;
  logic               cursor_hit;

  logic [ADDR_W-1:0]  char_addr_d, char_addr_q;
  side_t              s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
  logic               inv3_d, inv3_q;
  logic               pixel_d, pixel_q;
  logic [COLOR_W-1:0] rgb_d, rgb_q;
  logic               active_d, active_q;
  logic               hsync_d, hsync_q;
  logic               vsync_d, vsync_q;

  assign cell_x   = hpos[POS_W-1:3];
  assign cell_y   = vpos[POS_W-1:4];
  assign in_range = (32'(cell_x) < COLS) && (32'(cell_y) < ROWS);

`ifdef TEXT_CURSOR_EN
  logic [4:0] frame_cnt_d, frame_cnt_q;
  logic       vsync_prev_d, vsync_prev_q;

  // The frame counter advances on each rising edge of vsync_in.
  // Its bit 4 gives a blink period of 32 frames.
  always_comb begin
    vsync_prev_d = vsync_in;
    frame_cnt_d  = frame_cnt_q + 5'(vsync_in & ~vsync_prev_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q  <= '0;
      vsync_prev_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      vsync_prev_q <= vsync_prev_d;
    end
  end

  assign cursor_hit = (32'(cell_x) == 32'(cursor_col)) &&
                      (32'(cell_y) == 32'(cursor_row)) &&
                      (vpos[3:1] == 3'b111) && frame_cnt_q[4];
`else
  assign cursor_hit = 1'b0;
`endif

  // Stage 1: compute the cell address and capture the sub-cell position.
  // Off-screen cells read address 0 and are blanked through vis.
  always_comb begin
    char_addr_d = in_range ? ADDR_W'(32'(cell_y) * COLS + 32'(cell_x)) : '0;
    s1_d.cur  = cursor_hit;
    s1_d.vis  = active_in & in_range;
    s1_d.act  = active_in;
    s1_d.hs   = hsync_in;
    s1_d.vs   = vsync_in;
    s1_d.vsub = vpos[3:0];
    s1_d.hsub = hpos[2:0];
  end

  // Stages 2 and 3 only delay the sideband.
  // The inverse-video bit is captured when char_data is valid, in the same
  // clock in which the font memory takes font_addr.
  always_comb begin
    s2_d   = s1_q;
    s3_d   = s2_q;
    inv3_d = char_data[7];
  end

  // Output stage: select the glyph bit, then apply inversion, cursor and blanking.
  always_comb begin
    pixel_d  = (font_data[{s3_q.vsub, s3_q.hsub}] ^ inv3_q ^ s3_q.cur) & s3_q.vis;
    rgb_d    = pixel_d ? FG_COLOR : BG_COLOR;
    active_d = s3_q.act;
    hsync_d  = s3_q.hs;
    vsync_d  = s3_q.vs;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      char_addr_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      inv3_q      <= 1'b0;
      pixel_q     <= 1'b0;
      rgb_q       <= BG_COLOR;
      active_q    <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
    end else begin
      char_addr_q <= char_addr_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      inv3_q      <= inv3_d;
      pixel_q     <= pixel_d;
      rgb_q       <= rgb_d;
      active_q    <= active_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign char_addr  = char_addr_q;
  assign font_addr  = char_data[FONT_ADDR_W-1:0];
  assign pixel      = pixel_q;
  assign rgb        = rgb_q;
  assign active_out = active_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;

endmodule

// File: doc/text_pixel_gen.md
Name: text_pixel_gen

Overview:
- Text-mode renderer that sits between the VGA timing generator, the character (text) RAM and the font memory.
- Maps each pixel coordinate to a character cell and issues the text-RAM address.
- Forwards the returned character code to the font memory as its glyph address, then selects one bit of the returned 8x16 bitmap.
- Outputs pixel/colour plus hsync/vsync/active, all delayed by the same fixed latency.

Parameters:
- COLS, 80, character columns per line.
- ROWS, 30, character rows per frame.
- POS_W, 10, width of hpos/vpos.
- ADDR_W, 12, text-RAM address width; must hold COLS*ROWS-1.
- FONT_ADDR_W, 7, font memory address width (128 glyphs).
- COLOR_W, 3, width of rgb.
- FG_COLOR, 3'b111, foreground colour.
- BG_COLOR, 3'b000, background colour.

Ports:
- clk  in  1  pixel clock.
- rstn  in  1  asynchronous active-low reset.
- hpos  in  POS_W  current pixel x.
- vpos  in  POS_W  current pixel y.
- active_in  in  1  visible-area flag.
- hsync_in  in  1  horizontal sync from timing generator.
- vsync_in  in  1  vertical sync from timing generator.
- char_addr  out  ADDR_W  text-RAM read address (registered).
- char_data  in  8  text-RAM read data, valid 1 cycle after char_addr.
- font_addr  out  FONT_ADDR_W  glyph index = char_data[6:0] (combinational).
- font_data  in  128  glyph bitmap [0:127], valid 1 cycle after font_addr; bit index = row*8+col; bit 0 = top-left.
- pixel  out  1  glyph bit after inversion/masking.
- rgb  out  COLOR_W  FG_COLOR if pixel else BG_COLOR.
- active_out  out  1  active_in delayed 4 cycles.
- hsync_out  out  1  hsync_in delayed 4 cycles.
- vsync_out  out  1  vsync_in delayed 4 cycles.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rstn low asynchronously clears every register: char_addr=0, pixel=0, rgb=BG_COLOR, active_out/hsync_out/vsync_out=0, all pipeline and sideband registers 0, blink counter 0.
- Pipeline, with coordinates presented in the cycle ending at edge E:
  - E+1: char_addr <= (vpos>>4)*COLS + (hpos>>3). hpos[2:0], vpos[3:0], active_in, invert flag slot and syncs enter stage 1.
  - E+2: char_data valid from text RAM. font_addr follows char_data[6:0] combinationally. char_data[7] is captured as the inverse-video flag.
  - E+3: font memory registers font_data. Sideband advances.
  - E+4: pixel <= (font_data[vsub*8+hsub] XOR inv XOR cursor_hit) AND active. rgb, active_out and syncs are updated on the same edge.
- Latency is exactly 4 cycles for pixel, rgb, active_out, hsync_out and vsync_out.
- Out of range (hpos>>3 >= COLS or vpos>>4 >= ROWS):
  - char_addr <= 0.
  - The stage's active flag is forced 0.
  - pixel=0 and rgb=BG_COLOR at E+4.
- active_in low: pixel=0 and rgb=BG_COLOR regardless of glyph, inversion or cursor.
- Row multiply is by constant COLS; width is truncated to ADDR_W. Parameter check: COLS*ROWS <= 2^ADDR_W.
- No stalls or backpressure. One coordinate is accepted per clock, every clock.
- Reset mid-frame:
  - Pipeline contents are discarded.
  - After release, the first valid output appears 4 cycles after the first sampled coordinate.
  - The intervening outputs hold their reset values.

Optional Feature:
- Macro: TEXT_CURSOR_EN.
- Defined:
  - Adds inputs cursor_col (7b) and cursor_row (5b).
  - Adds a 5-bit frame counter that increments on each rising edge of vsync_in (edge detected with a registered copy).
  - cursor_hit = 1 when the cell equals (cursor_col,cursor_row), vsub is 14 or 15, and counter[4]=1. Blink is 16 frames on, 16 off.
  - cursor_hit is pipelined to align with E+4.
  - The counter resets to 0.
- Undefined: no cursor ports or counter; cursor_hit is constant 0.

Test Plan:
- Address mapping: hpos=639,vpos=479,active=1 -> char_addr=2399 at E+1. hpos=8,vpos=16 -> char_addr=81.
- Glyph select: char_data=0x41 returned, font_data row0=8'b00011000, hpos=3,vpos=0 -> font_addr=0x41 at E+2; pixel=1, rgb=3'b111 at E+4. hpos=0 gives pixel=0, rgb=3'b000.
- Inverse video: char_data=0xC1 with the same font_data, hpos=0,vpos=0 -> pixel=1. hpos=3 -> pixel=0.
- Blanking/sync alignment: active_in=0 with a font bit of 1 -> pixel=0. An hsync_in pulse at cycle N -> hsync_out pulse at N+4, with the same width.
- Reset: assert rstn=0 mid-line -> all outputs 0 immediately (asynchronous), rgb=BG_COLOR. Release, then present hpos=3,vpos=0 -> valid pixel 4 cycles later.
- TEXT_CURSOR_EN: cursor at (0,0), vpos=14, hpos=0, glyph bit 0:
  - pixel=0 for frames 0-15.
  - pixel=1 for frames 16-31.
  - vpos=13 -> pixel always 0.
